lsu_mem: RTL
============

Name: lsu_mem

Overview:
- Memory stage of the 5-stage core. Sits between ex and the register-file write-back port.
- Non-memory results pass through a 1-cycle register.
- Loads and stores run a bus request/grant/rvalid handshake. The pipeline stalls until the access completes.
- Drives the regu write-back port (regu_rd_*_i) from registered outputs. Drives the regu conflict2 port from combinational forwarding outputs.

Parameters:
- ADDR_W, 32, bus address width.
- DATA_W, 32, register/bus data width (word = 4 byte lanes).
- REG_AW, 5, register address width (32 registers).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid_i  in  1  ex holds a valid instruction.
- ex_rd_addr_i  in  REG_AW  destination register.
- ex_rd_data_i  in  DATA_W  ALU result; effective address for memory ops.
- ex_rd_wr_en_i  in  1  instruction writes rd.
- ex_mem_rd_i  in  1  load.
- ex_mem_we_i  in  1  store (ex_mem_rd_i and ex_mem_we_i are never both 1).
- ex_mem_funct3_i  in  3  access size/sign (RV32I funct3).
- ex_mem_wdata_i  in  DATA_W  store data (rs2).
- stall_o  out  1  hold ex/id/if this cycle.
- bus_req_o  out  1  access request.
- bus_we_o  out  1  1 = write.
- bus_addr_o  out  ADDR_W  word-aligned address ({addr[31:2],2'b00}).
- bus_be_o  out  4  byte enables.
- bus_wdata_o  out  DATA_W  lane-replicated store data.
- bus_gnt_i  in  1  request accepted.
- bus_rvalid_i  in  1  read data valid.
- bus_rdata_i  in  DATA_W  read data.
- mem_rd_addr_o  out  REG_AW  registered, to regu_rd_addr_i.
- mem_rd_data_o  out  DATA_W  registered, to regu_rd_data_i.
- mem_rd_wr_en_o  out  1  registered, to regu_rd_wr_en_i.
- fwd_rd_addr_o, fwd_rd_data_o, fwd_rd_wr_en_o  out  REG_AW/DATA_W/1  combinational, to regu conflict2 port.
- misalign_o  out  1  (feature only) registered misaligned-access flag.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All registered outputs (bus_*, mem_rd_*, misalign_o) are 0. Reset mid-access abandons the transaction; no write-back occurs.
- FSM states:
  - IDLE:
    - On ex_valid_i && (mem_rd|mem_we), latch the access (addr, funct3, rd, wdata lanes/be). Next state REQ, bus_req_o=1 from the next cycle.
    - Otherwise the result passes through: mem_rd_* <= ex_rd_* at the edge; wr_en = ex_valid_i && ex_rd_wr_en_i && (ex_rd_addr_i!=0).
  - REQ: bus_req_o and bus_* stay stable until bus_gnt_i.
    - Store + gnt: go to IDLE; bus_req_o drops the next cycle.
    - Load + gnt: go to WAIT; bus_req_o drops the next cycle.
  - WAIT: on bus_rvalid_i, register the formatted load data into mem_rd_* (wr_en=1 unless rd=0) and go to IDLE. rvalid in the same cycle as gnt is not legal.
- stall_o (combinational) is 1 when (IDLE && ex_valid_i && memop) || REQ && !(store && gnt) || WAIT && !rvalid. ex therefore advances at the edge that completes the access.
- mem_rd_wr_en_o is 0 on every edge where no instruction completes, so bubbles never write.
- Load latency: accept edge, then ≥1 REQ cycle, then ≥1 WAIT cycle. Minimum 3 cycles from ex presentation to mem_rd_wr_en_o=1.
- Store formatting (lanes by addr[1:0]):
  - SB(000): be=1<<a, wdata={4{b}}.
  - SH(001): be=a[1]?1100:0011, wdata={2{h}}.
  - SW(010): be=1111.
- Load formatting: LB(000)/LBU(100) select byte a, sign-/zero-extend. LH(001)/LHU(101) select half a[1], extend. LW(010) whole word.
- Reserved funct3 (011,110,111) are treated as word access.
- Forwarding: fwd_* = ex_rd_* with fwd_rd_wr_en_o = ex_valid_i && ex_rd_wr_en_i && !ex_mem_rd_i && state==IDLE. Loads are never forwarded before data returns.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Enabled: LH/LHU/SH with a[0]=1, or LW/SW with a[1:0]!=0, issue no bus request. misalign_o=1 for one cycle at the next edge, mem_rd_wr_en_o=0, no stall beyond the presentation cycle.
- Disabled: misalign_o is tied 0. Misaligned accesses proceed with low address bits ignored for lane selection of halves/words (aligned-down behaviour).

Test Plan:
- ALU op: ex_valid=1, rd=5, data=0x1234, wr_en=1, no memop -> next edge mem_rd_addr=5, data=0x1234, wr_en=1, stall_o=0 throughout.
- LB at 0x103, gnt after 2 REQ cycles, rvalid after 1 WAIT, rdata=0x80FFFFFF -> bus_addr=0x100, mem_rd_data=0xFFFFFF80, stall_o high until the rvalid cycle.
- SH at 0x202, wdata=0xABCD1234, gnt immediately -> bus_be=1100, bus_wdata=0x12341234, bus_we=1, mem_rd_wr_en=0.
- LHU at 0x8 to rd=0, rdata=0x0000F00D -> mem_rd_wr_en=0; fwd_rd_wr_en=0 while in REQ/WAIT.
- rst_n pulsed low during WAIT -> bus_req=0, state IDLE, no write-back after late rvalid.
- (LSU_MISALIGN_TRAP_EN) LW at 0x6 -> no bus_req, misalign_o=1 one cycle, wr_en=0.

Source files
------------

// File: rtl/lsu_mem.sv
// lsu_mem - memory stage of the 5-stage core.
//
// Non-memory results from ex are registered for one cycle and presented to
// the register-file write-back port. Loads and stores run a
// request/grant/rvalid bus handshake. stall_o holds the upstream stages
// until the access completes.
//
// Optional build macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses are not issued to the bus.
//               misalign_o pulses for one cycle instead.
//   undefined : misalign_o is tied 0. Misaligned halves/words use the
//               aligned-down lane.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   ex_*                  instruction presented by ex (rd, result/address,
//                         load/store controls, store data)
//   stall_o               hold ex/id/if this cycle (combinational)
//   bus_*_o / bus_*_i     data bus request/grant/rvalid handshake
//                         (outputs registered)
//   mem_rd_*_o            registered write-back to the register file
//   fwd_rd_*_o            combinational forwarding to the hazard unit
//   misalign_o            registered misaligned-access flag
module lsu_mem #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid_i,
  input  logic [REG_AW-1:0] ex_rd_addr_i,
  input  logic [DATA_W-1:0] ex_rd_data_i,
  input  logic              ex_rd_wr_en_i,
  input  logic              ex_mem_rd_i,
  input  logic              ex_mem_we_i,
  input  logic [2:0]        ex_mem_funct3_i,
  input  logic [DATA_W-1:0] ex_mem_wdata_i,
  output logic              stall_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic [REG_AW-1:0] mem_rd_addr_o,
  output logic [DATA_W-1:0] mem_rd_data_o,
  output logic              mem_rd_wr_en_o,
  output logic [REG_AW-1:0] fwd_rd_addr_o,
  output logic [DATA_W-1:0] fwd_rd_data_o,
  output logic              fwd_rd_wr_en_o,
  output logic              misalign_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e            state_r;
  state_e            state_nxt_s;
  logic [2:0]        funct3_r;
  logic [1:0]        lane_r;
  logic [REG_AW-1:0] rd_addr_r;
  logic              memop_s;
  logic              misalign_s;
  logic              accept_s;

  // Byte enables for a store. funct3[1:0] gives the size. Reserved codes
  // fall into the word case.
  function automatic logic [3:0] store_be(input logic [2:0] f, input logic [1:0] a);
    logic [3:0] be;
    case (f[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data is replicated across lanes so the byte enables alone pick
  // the target bytes.
  function automatic logic [DATA_W-1:0] store_data(input logic [2:0] f, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] w;
    case (f[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Extract and extend load data. funct3[2] set means zero-extend.
  function automatic logic [DATA_W-1:0] load_data(input logic [2:0] f, input logic [1:0] a,
                                                  input logic [DATA_W-1:0] d);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    case (a)
      2'b00:   b = d[7:0];
      2'b01:   b = d[15:8];
      2'b10:   b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (f[1:0])
      2'b00:   r = {{24{b[7] & ~f[2]}}, b};
      2'b01:   r = {{16{h[15] & ~f[2]}}, h};
      default: r = d;
    endcase
    return r;
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  // Half accesses need an even address. Word accesses, including reserved
  // funct3 codes, need a 4-byte-aligned address.
  function automatic logic is_misaligned(input logic [2:0] f, input logic [1:0] a);
    logic m;
    case (f[1:0])
      2'b00:   m = 1'b0;
      2'b01:   m = a[0];
      default: m = |a;
    endcase
    return m;
  endfunction

  assign misalign_s = memop_s && is_misaligned(ex_mem_funct3_i, ex_rd_data_i[1:0]);
`else
  assign misalign_s = 1'b0;
`endif

  assign memop_s  = ex_valid_i && (ex_mem_rd_i || ex_mem_we_i);
  // A trapped access is consumed in its presentation cycle without a bus request.
  assign accept_s = memop_s && !misalign_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus_gnt_i) begin
          state_nxt_s = bus_we_o ? ST_IDLE : ST_WAIT;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (bus_rvalid_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Stall and forwarding outputs
  always_comb begin
    stall_o        = 1'b0;
    fwd_rd_addr_o  = ex_rd_addr_i;
    fwd_rd_data_o  = ex_rd_data_i;
    fwd_rd_wr_en_o = ex_valid_i && ex_rd_wr_en_i && !ex_mem_rd_i && (state_r == ST_IDLE);
    case (state_r)
      ST_IDLE: stall_o = accept_s;
      ST_REQ:  stall_o = !(bus_we_o && bus_gnt_i);
      ST_WAIT: stall_o = !bus_rvalid_i;
      default: stall_o = 1'b0;
    endcase
  end

  // Bus request, latched access context and write-back registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req_o      <= 1'b0;
      bus_we_o       <= 1'b0;
      bus_addr_o     <= {ADDR_W{1'b0}};
      bus_be_o       <= 4'b0000;
      bus_wdata_o    <= {DATA_W{1'b0}};
      funct3_r       <= 3'b000;
      lane_r         <= 2'b00;
      rd_addr_r      <= {REG_AW{1'b0}};
      mem_rd_addr_o  <= {REG_AW{1'b0}};
      mem_rd_data_o  <= {DATA_W{1'b0}};
      mem_rd_wr_en_o <= 1'b0;
    end else begin
      // No write-back unless an instruction completes at this edge.
      mem_rd_wr_en_o <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= ex_mem_we_i;
            bus_addr_o  <= {ex_rd_data_i[ADDR_W-1:2], 2'b00};
            bus_be_o    <= store_be(ex_mem_funct3_i, ex_rd_data_i[1:0]);
            bus_wdata_o <= store_data(ex_mem_funct3_i, ex_mem_wdata_i);
            funct3_r    <= ex_mem_funct3_i;
            lane_r      <= ex_rd_data_i[1:0];
            rd_addr_r   <= ex_rd_addr_i;
          end else begin
            mem_rd_addr_o  <= ex_rd_addr_i;
            mem_rd_data_o  <= ex_rd_data_i;
            mem_rd_wr_en_o <= ex_valid_i && ex_rd_wr_en_i && !memop_s &&
                              (ex_rd_addr_i != {REG_AW{1'b0}});
          end
        end
        ST_REQ: begin
          if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
          end else begin
            bus_req_o <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (bus_rvalid_i) begin
            mem_rd_addr_o  <= rd_addr_r;
            mem_rd_data_o  <= load_data(funct3_r, lane_r, bus_rdata_i);
            mem_rd_wr_en_o <= (rd_addr_r != {REG_AW{1'b0}});
          end else begin
            mem_rd_wr_en_o <= 1'b0;
          end
        end
        default: bus_req_o <= 1'b0;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // One-cycle misaligned-access flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= (state_r == ST_IDLE) && misalign_s;
    end
  end
`else
  assign misalign_o = 1'b0;
`endif

endmodule
